// File: rtl/int_ack_if.sv
// INT/INTA handshake between the CPU-side acknowledge initiator and the PIC.
// master is the initiator (drives inta_n and the captured results), slave is the PIC side.
interface int_ack_if;
  logic        int_req;
  logic        enable;
  logic        mode_8086;
  logic [7:0]  data_in;
  logic        inta_n;
  logic        busy;
  logic [7:0]  vector;
  logic [15:0] vec_addr;
  logic        vector_valid;
  logic        seq_err;

  modport master (
    input  int_req, enable, mode_8086, data_in,
    output inta_n, busy, vector, vec_addr, vector_valid, seq_err
  );

  modport slave (
    output int_req, enable, mode_8086, data_in,
    input  inta_n, busy, vector, vec_addr, vector_valid, seq_err
  );
endinterface

// File: rtl/int_ack_initiator.sv
// CPU-side interrupt-acknowledge initiator: synchronises INT and runs the
// 8086 two-pulse or 8080 three-pulse INTA sequence, capturing vector data.
//
// state | meaning
// IDLE  | waiting for synchronised int_req with enable set
// LOW   | inta_n driven low for PULSE_CYCLES; data_in sampled on the last edge
// GAP   | inta_n high for GAP_CYCLES between pulses
// DONE  | one cycle; results/strobes registered on the edge leaving it
// HOLD  | HOLDOFF cycles where int_req is ignored
module int_ack_initiator #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int HOLDOFF      = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  int_ack_if.master ack
);

  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_PG > HOLDOFF) ? MAX_PG : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [7:0]    CALL_OP    = 8'hCD;

  typedef enum logic [2:0] {IDLE, LOW, GAP, DONE, HOLD} state_t;

  state_t         state, state_nxt;
  logic           sync1, int_sync;
  logic [CW-1:0]  cnt;
  logic           mode_q;
  logic [1:0]     npulse;
  logic [7:0]     byte0, byte1, byte2;
  logic           last_pulse;
  logic           call_ok;

  logic           inta_n_q, busy_q, vv_q, err_q;
  logic [7:0]     vector_q;
  logic [15:0]    vec_addr_q;
  logic           inta_n_nxt, busy_nxt, vv_nxt, err_nxt;

  // npulse counts completed pulses, so this pulse is last when one short of the total
  assign last_pulse = (npulse == (mode_q ? 2'd1 : 2'd2));
  assign call_ok    = (byte0 == CALL_OP);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (int_sync && ack.enable) state_nxt = LOW;
      LOW:  if (cnt == '0) state_nxt = last_pulse ? DONE : GAP;
      GAP:  if (cnt == '0) state_nxt = LOW;
      DONE: state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output decode; registered below so inta_n/busy track the state exactly
  always_comb begin
    inta_n_nxt = (state_nxt != LOW);
    busy_nxt   = (state_nxt == LOW) || (state_nxt == GAP) || (state_nxt == DONE);
    vv_nxt     = (state == DONE) && (mode_q || call_ok);
    err_nxt    = (state == DONE) && !mode_q && !call_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      sync1    <= ack.int_req;
      int_sync <= sync1;
    end
  end

  // phase timer: loaded on state entry, counts down to terminal zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        LOW:     cnt <= PULSE_LOAD;
        GAP:     cnt <= GAP_LOAD;
        HOLD:    cnt <= HOLD_LOAD;
        default: cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      npulse <= 2'd0;
      byte0  <= 8'h00;
      byte1  <= 8'h00;
      byte2  <= 8'h00;
    end else if (state == IDLE && state_nxt == LOW) begin
      mode_q <= ack.mode_8086;
      npulse <= 2'd0;
    end else if (state == LOW && cnt == '0) begin
      case (npulse)
        2'd0:    byte0 <= ack.data_in;
        2'd1:    byte1 <= ack.data_in;
        default: byte2 <= ack.data_in;
      endcase
      npulse <= npulse + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      vv_q       <= 1'b0;
      err_q      <= 1'b0;
      vector_q   <= 8'h00;
      vec_addr_q <= 16'h0000;
    end else begin
      inta_n_q <= inta_n_nxt;
      busy_q   <= busy_nxt;
      vv_q     <= vv_nxt;
      err_q    <= err_nxt;
      if (state == DONE && mode_q)             vector_q   <= byte1;
      if (state == DONE && !mode_q && call_ok) vec_addr_q <= {byte2, byte1};
    end
  end

  assign ack.inta_n       = inta_n_q;
  assign ack.busy         = busy_q;
  assign ack.vector       = vector_q;
  assign ack.vec_addr     = vec_addr_q;
  assign ack.vector_valid = vv_q;
  assign ack.seq_err      = err_q;

endmodule
